// File: rtl/ber_monitor_rx.sv
// Receive-side BER monitor: counts invalid sync headers across PCS lanes,
// declares hi_ber per observation window and keeps a saturating error total.
module ber_monitor_rx #(
    parameter int LANE_N     = 4,
    parameter int HEAD_W     = 2,
    parameter int WINDOW_CYC = 200000,
    parameter int BER_THRESH = 97,
    parameter int WIN_CNT_W  = 8,
    parameter int ERR_CNT_W  = 22
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [LANE_N-1:0]        valid_i,
    input  logic [LANE_N-1:0]        lock_v_i,
    input  logic [LANE_N*HEAD_W-1:0] head_i,
    input  logic                     clr_i,
    output logic                     hi_ber_o,
    output logic                     win_done_o,
    output logic [ERR_CNT_W-1:0]     ber_cnt_o
);

    localparam int TIMER_W = $clog2(WINDOW_CYC);
    localparam int BN_W    = $clog2(LANE_N + 1);
    localparam int WSUM_W  = WIN_CNT_W + BN_W;
    localparam int ESUM_W  = ERR_CNT_W + BN_W;

    typedef enum logic [1:0] {INIT, TEST, HI_BER} state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic [WIN_CNT_W-1:0] win_cnt;
    logic [BN_W-1:0]      bad_n;
    logic                 all_lock;
    logic                 win_end;
    logic                 thresh_hit;
    logic [WSUM_W-1:0]    win_sum;
    logic [WIN_CNT_W-1:0] win_next;

    function automatic logic [ERR_CNT_W-1:0] sat_err(input logic [ESUM_W-1:0] sum);
        if (sum > ESUM_W'({ERR_CNT_W{1'b1}}))
            return {ERR_CNT_W{1'b1}};
        return sum[ERR_CNT_W-1:0];
    endfunction

    always_comb begin
        logic [HEAD_W-1:0] hd;
        bad_n = '0;
        for (int l = 0; l < LANE_N; l++) begin
            hd = head_i[l*HEAD_W +: HEAD_W];
            if (valid_i[l] && lock_v_i[l] && (hd == '0 || hd == '1))
                bad_n = bad_n + 1'b1;
        end
    end

    assign all_lock   = &lock_v_i;
    assign win_end    = (timer == TIMER_W'(WINDOW_CYC - 1));
    assign win_sum    = WSUM_W'(win_cnt) + WSUM_W'(bad_n);
    // Once the threshold is reached the window count is held there.
    assign thresh_hit = (win_sum >= WSUM_W'(BER_THRESH));
    assign win_next   = thresh_hit ? WIN_CNT_W'(BER_THRESH) : win_sum[WIN_CNT_W-1:0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= INIT;
            timer      <= '0;
            win_cnt    <= '0;
            hi_ber_o   <= 1'b0;
            win_done_o <= 1'b0;
        end else begin
            win_done_o <= 1'b0;
            if (!all_lock) begin
                state    <= INIT;
                timer    <= '0;
                win_cnt  <= '0;
                hi_ber_o <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        state    <= TEST;
                        timer    <= '0;
                        win_cnt  <= '0;
                        hi_ber_o <= 1'b0;
                    end
                    default: begin
                        win_done_o <= win_end;
                        timer      <= win_end ? '0 : timer + 1'b1;
                        win_cnt    <= win_end ? '0 : win_next;
                        if (state == TEST) begin
                            // Threshold crossing wins even on the window-end cycle.
                            if (thresh_hit) begin
                                state    <= HI_BER;
                                hi_ber_o <= 1'b1;
                            end
                        end else if (win_end && !thresh_hit) begin
                            state    <= TEST;
                            hi_ber_o <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            ber_cnt_o <= '0;
        else if (clr_i)
            ber_cnt_o <= ERR_CNT_W'(bad_n);
        else
            ber_cnt_o <= sat_err(ESUM_W'(ber_cnt_o) + ESUM_W'(bad_n));
    end

endmodule

// File: tb/tb_ber_monitor_rx.sv
// Bench for ber_monitor_rx: directed scenarios plus random traffic, checked
// every cycle against a window-total reference model.
module tb_ber_monitor_rx;

    localparam int LANE_N = 4;
    localparam int HEAD_W = 2;
    localparam int WIN    = 16;
    localparam int TH     = 4;
    localparam int ECW    = 4;
    localparam int EMAX   = 15;

    logic                     clk = 1'b0;
    logic                     nreset = 1'b1;
    logic [LANE_N-1:0]        valid_i = '0;
    logic [LANE_N-1:0]        lock_v_i = '0;
    logic [LANE_N*HEAD_W-1:0] head_i = 8'h55;
    logic                     clr_i = 1'b0;
    logic                     hi_ber_o;
    logic                     win_done_o;
    logic [ECW-1:0]           ber_cnt_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    ber_monitor_rx #(
        .LANE_N(LANE_N), .HEAD_W(HEAD_W), .WINDOW_CYC(WIN), .BER_THRESH(TH),
        .WIN_CNT_W(8), .ERR_CNT_W(ECW)
    ) dut (
        .clk(clk), .nreset(nreset), .valid_i(valid_i), .lock_v_i(lock_v_i),
        .head_i(head_i), .clr_i(clr_i), .hi_ber_o(hi_ber_o),
        .win_done_o(win_done_o), .ber_cnt_o(ber_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks whole-window bad totals and mode, not counters.
    bit m_init = 1, m_hi = 0, m_done = 0;
    int m_pos = 0, m_tot = 0, m_cum = 0;

    function automatic int count_bad();
        int n = 0;
        logic [HEAD_W-1:0] h;
        for (int l = 0; l < LANE_N; l++) begin
            h = head_i[l*HEAD_W +: HEAD_W];
            if (valid_i[l] && lock_v_i[l] && (h == 2'b00 || h == 2'b11)) n++;
        end
        return n;
    endfunction

    always @(posedge clk or negedge nreset) begin
        int nb;
        if (!nreset) begin
            m_init = 1; m_hi = 0; m_done = 0; m_pos = 0; m_tot = 0; m_cum = 0;
        end else begin
            nb = count_bad();
            m_done = 0;
            if (lock_v_i != '1) begin
                m_init = 1; m_pos = 0; m_tot = 0; m_hi = 0;
            end else if (m_init) begin
                m_init = 0; m_pos = 0; m_tot = 0;
            end else begin
                m_tot += nb;
                if (!m_hi) begin
                    if (m_tot >= TH) m_hi = 1;
                end else if (m_pos == WIN - 1 && m_tot < TH) begin
                    m_hi = 0;
                end
                if (m_pos == WIN - 1) begin
                    m_done = 1; m_pos = 0; m_tot = 0;
                end else begin
                    m_pos++;
                end
            end
            m_cum = clr_i ? nb : m_cum + nb;
        end
    end

    always @(negedge clk) begin
        if (chk_en && nreset) begin
            check("model_hi_ber", int'(hi_ber_o), int'(m_hi));
            check("model_win_done", int'(win_done_o), int'(m_done));
            check("model_ber_cnt", int'(ber_cnt_o), (m_cum > EMAX) ? EMAX : m_cum);
        end
    end

    initial begin
        int pulses, n;
        bit hi_seen;

        #1 nreset = 1'b0;
        #1;
        check("reset_hi_ber", int'(hi_ber_o), 0);
        check("reset_win_done", int'(win_done_o), 0);
        check("reset_ber_cnt", int'(ber_cnt_o), 0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        chk_en = 1;

        // Clean, locked traffic
        lock_v_i = '1; valid_i = '1; head_i = 8'h55;
        repeat (3) @(negedge clk);
        pulses = 0;
        repeat (64) begin
            @(negedge clk);
            pulses += int'(win_done_o);
        end
        check("clean_pulses", pulses, 4);
        check("clean_hi_ber", int'(hi_ber_o), 0);
        check("clean_ber_cnt", int'(ber_cnt_o), 0);

        // All four lanes bad for one cycle
        head_i = 8'hFF;
        @(negedge clk);
        head_i = 8'h55;
        check("burst_hi_ber", int'(hi_ber_o), 1);
        check("burst_ber_cnt", int'(ber_cnt_o), 4);
        n = 0;
        while (hi_ber_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("burst_hi_clear", int'(hi_ber_o), 0);

        // Clear-on-read with concurrent bad lanes
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        check("clr_zero", int'(ber_cnt_o), 0);
        head_i = 8'h54;
        repeat (9) @(negedge clk);
        head_i = 8'h55;
        check("cnt_nine", int'(ber_cnt_o), 9);
        head_i = 8'h50; clr_i = 1'b1;
        @(negedge clk);
        head_i = 8'h55; clr_i = 1'b0;
        check("clr_load_two", int'(ber_cnt_o), 2);

        // Three bad headers in every window: no hi_ber, counter saturates
        repeat (40) @(negedge clk);
        hi_seen = 0;
        for (int i = 0; i < 96; i++) begin
            head_i = ((i % WIN) < 3) ? 8'h54 : 8'h55;
            @(negedge clk);
            hi_seen |= hi_ber_o;
        end
        head_i = 8'h55;
        check("three_per_win_hi", int'(hi_seen), 0);
        check("cnt_saturated", int'(ber_cnt_o), EMAX);

        // Lock drop while hi_ber is set
        head_i = 8'hFF;
        @(negedge clk);
        head_i = 8'h55;
        check("pre_drop_hi", int'(hi_ber_o), 1);
        lock_v_i = 4'b1011;
        @(negedge clk);
        lock_v_i = '1;
        check("drop_hi_clear", int'(hi_ber_o), 0);
        n = 0;
        while (!win_done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("relock_first_window", n, 17);

        // Asynchronous reset mid-window with hi_ber set
        head_i = 8'hFF;
        @(negedge clk);
        head_i = 8'h55;
        check("pre_reset_hi", int'(hi_ber_o), 1);
        @(posedge clk);
        #2 nreset = 1'b0;
        #1;
        check("async_hi_ber", int'(hi_ber_o), 0);
        check("async_win_done", int'(win_done_o), 0);
        check("async_ber_cnt", int'(ber_cnt_o), 0);
        @(negedge clk);
        nreset = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [LANE_N*HEAD_W-1:0] h;
            lock_v_i = ($urandom_range(0, 49) == 0) ? 4'($urandom) : '1;
            valid_i  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '1;
            for (int l = 0; l < LANE_N; l++) begin
                if ($urandom_range(0, 11) == 0)
                    h[l*HEAD_W +: HEAD_W] = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                else
                    h[l*HEAD_W +: HEAD_W] = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            end
            head_i = h;
            clr_i  = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        clr_i = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
